// File: rtl/tdm_select_sequencer_pkg.sv
// Shared definitions for the TDM select sequencer: state encoding, channel count,
// select width and small mask helpers.
package tdm_select_sequencer_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = SEL_W'(i);
    end
  endfunction

  function automatic logic [SEL_W-1:0] highest_set(input logic [NUM_CH-1:0] m);
    highest_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m[i]) highest_set = SEL_W'(i);
    end
  endfunction
endpackage

// File: rtl/tdm_select_sequencer_next_ch_finder.sv
// Combinational search for the next enabled channel above the current index.
// When no higher bit is set the result wraps to the lowest enabled channel.
module next_ch_finder
  import tdm_select_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              wrap,
  output logic              last
);
  always_comb begin
    nxt  = lowest_set(mask);
    wrap = 1'b1;
    // Scan downward so the closest higher set bit is the one that sticks.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        nxt  = SEL_W'(i);
        wrap = 1'b0;
      end
    end
    last = wrap;
  end
endmodule

// File: rtl/tdm_select_sequencer.sv
// Steps a registered 4:1 mux select through the enabled channels of a latched mask,
// holding each for DWELL cycles, with frame start/done pulses and continuous mode.
module tdm_select_sequencer
  import tdm_select_sequencer_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       stop,
  input  logic [3:0] ch_en,
  output logic [1:0] s,
  output logic       s_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       busy,
  output logic       dbg_state
);
  // Handshake: start is a one-cycle request sampled only in IDLE; stop and rst are
  // level requests honoured at the next rising edge; outputs are all registered.
  localparam logic [7:0] CNT_LAST  = 8'(DWELL - 1);
  localparam logic       ONE_CYCLE = (DWELL == 1);

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [SEL_W-1:0]  s_d, nxt;
  logic              sv_d, fs_d, fd_d;
  logic              wrap, last;

  next_ch_finder u_finder (
    .mask (mask_q),
    .cur  (s),
    .nxt  (nxt),
    .wrap (wrap),
    .last (last)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    s_d     = s;
    sv_d    = 1'b0;
    fs_d    = 1'b0;
    fd_d    = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (ch_en != '0)) begin
            state_d = ST_RUN;
            mask_d  = ch_en;
            s_d     = lowest_set(ch_en);
            cnt_d   = '0;
            sv_d    = 1'b1;
            fs_d    = 1'b1;
            fd_d    = ONE_CYCLE && (lowest_set(ch_en) == highest_set(ch_en));
          end
        end
        ST_RUN: begin
          sv_d = 1'b1;
          // frame_done is registered, so it is predicted one cycle early.
          if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 8'd1;
            fd_d  = last && ((cnt_q + 8'd1) == CNT_LAST);
          end else if (!wrap) begin
            s_d   = nxt;
            cnt_d = '0;
            fd_d  = ONE_CYCLE && (nxt == highest_set(mask_q));
          end else if (cont && (ch_en != '0)) begin
            mask_d = ch_en;
            s_d    = lowest_set(ch_en);
            cnt_d  = '0;
            fs_d   = 1'b1;
            fd_d   = ONE_CYCLE && (lowest_set(ch_en) == highest_set(ch_en));
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sv_d    = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      cnt_q       <= '0;
      s           <= '0;
      s_valid     <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      s           <= s_d;
      s_valid     <= sv_d;
      frame_start <= fs_d;
      frame_done  <= fd_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign dbg_state = state_q;
endmodule
